// File: rtl/sram_host_port_if.sv
// Host-side data bus of sram_host_port: core-style req/gnt request channel
// plus a rvalid/rready response channel. Signal suffixes are from the adapter's view.
interface sram_host_port_if #(
    parameter int Width = 32
) ();
    localparam int WidthBytes = Width / 8;

    logic                  req_i;
    logic                  gnt_o;
    logic                  we_i;
    logic [WidthBytes-1:0] be_i;
    logic [31:0]           addr_i;
    logic [Width-1:0]      wdata_i;
    logic                  rvalid_o;
    logic                  rready_i;
    logic [Width-1:0]      rdata_o;
    logic                  err_o;

    modport master (
        output req_i, we_i, be_i, addr_i, wdata_i, rready_i,
        input  gnt_o, rvalid_o, rdata_o, err_o
    );

    modport slave (
        input  req_i, we_i, be_i, addr_i, wdata_i, rready_i,
        output gnt_o, rvalid_o, rdata_o, err_o
    );
endinterface

// File: rtl/sram_host_port.sv
// Host bus to single-port SRAM adapter with a credit-controlled response FIFO.
// Define SRAM_HOST_CLEAR_EN to zero-fill the whole SRAM after every reset.
module sram_host_port #(
    parameter  int Width      = 32,
    parameter  int Depth      = 1 << 15,
    parameter  int RespDepth  = 2,
    localparam int WidthBytes = Width / 8,
    localparam int Aw         = $clog2(Depth),
    localparam int Off        = $clog2(WidthBytes)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    sram_host_port_if.slave  host,
    output logic             sram_req_o,
    output logic             sram_write_o,
    output logic [Aw-1:0]    sram_addr_o,
    output logic [Width-1:0] sram_wdata_o,
    output logic [Width-1:0] sram_wmask_o,
    input  logic [Width-1:0] sram_rdata_i
);
    localparam int Cw  = $clog2(RespDepth + 1);
    localparam int Cw1 = Cw + 1;
    localparam int Pw  = (RespDepth > 1) ? $clog2(RespDepth) : 1;

    typedef enum logic {ST_CLEAR, ST_READY} state_e;

    state_e                        state_q, state_d;
    logic                          inflight_q, inflight_d;
    logic                          infl_read_q, infl_read_d;
    logic                          infl_err_q, infl_err_d;
    logic [Cw-1:0]                 occ_q, occ_d;
    logic [Pw-1:0]                 wptr_q, wptr_d;
    logic [Pw-1:0]                 rptr_q, rptr_d;
    logic [RespDepth-1:0][Width-1:0] fdata_q, fdata_d;
    logic [RespDepth-1:0]          ferr_q, ferr_d;
`ifdef SRAM_HOST_CLEAR_EN
    logic [Aw-1:0]                 clr_cnt_q, clr_cnt_d;
`endif

    logic             oor;
    logic             pop;
    logic             push;
    logic             accept;
    logic             credit_ok;
    logic [Cw1-1:0]   committed;
    logic [Width-1:0] be_mask;
    logic [Width-1:0] push_data;
    logic [Aw-1:0]    word_addr;

    function automatic logic [Pw-1:0] ptr_inc(input logic [Pw-1:0] p);
        return (p == Pw'(RespDepth - 1)) ? '0 : p + Pw'(1);
    endfunction

    for (genvar k = 0; k < WidthBytes; k++) begin : g_mask
        assign be_mask[8*k +: 8] = {8{host.be_i[k]}};
    end

    if (Aw + Off < 32) begin : g_oor
        assign oor = |host.addr_i[31:Aw+Off];
    end else begin : g_no_oor
        assign oor = 1'b0;
    end

    // Sub-word address bits carry no meaning for a word-wide SRAM.
    if (Off > 0) begin : g_low_addr
        logic unused_low_addr;
        assign unused_low_addr = ^host.addr_i[Off-1:0];
    end

    assign word_addr = host.addr_i[Aw+Off-1:Off];

    // Credit counts FIFO entries plus the access still in the SRAM pipe, so
    // an accept can never find the FIFO full when its data arrives.
    assign pop       = host.rvalid_o && host.rready_i;
    assign committed = Cw1'(occ_q) + Cw1'(inflight_q) - Cw1'(pop);
    assign credit_ok = committed < Cw1'(RespDepth);
    assign accept    = host.req_i && !rst_i && (state_q == ST_READY) && credit_ok;

    assign host.gnt_o    = accept;
    assign host.rvalid_o = (occ_q != '0);
    assign host.rdata_o  = host.rvalid_o ? fdata_q[rptr_q] : '0;
    assign host.err_o    = host.rvalid_o && ferr_q[rptr_q];

    always_comb begin
        sram_req_o   = 1'b0;
        sram_write_o = 1'b0;
        sram_addr_o  = '0;
        sram_wdata_o = '0;
        sram_wmask_o = '0;
        if (accept && !oor) begin
            sram_req_o   = 1'b1;
            sram_write_o = host.we_i;
            sram_addr_o  = word_addr;
            sram_wdata_o = host.wdata_i;
            sram_wmask_o = be_mask;
        end
`ifdef SRAM_HOST_CLEAR_EN
        else if (!rst_i && state_q == ST_CLEAR) begin
            sram_req_o   = 1'b1;
            sram_write_o = 1'b1;
            sram_addr_o  = clr_cnt_q;
            sram_wmask_o = '1;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
`ifdef SRAM_HOST_CLEAR_EN
        clr_cnt_d = clr_cnt_q;
        if (state_q == ST_CLEAR) begin
            clr_cnt_d = clr_cnt_q + Aw'(1);
            if (clr_cnt_q == Aw'(Depth - 1)) begin
                state_d   = ST_READY;
                clr_cnt_d = '0;
            end
        end
`endif
    end

    assign push      = inflight_q;
    assign push_data = (infl_read_q && !infl_err_q) ? sram_rdata_i : '0;

    always_comb begin
        inflight_d  = accept;
        infl_read_d = accept && !host.we_i;
        infl_err_d  = accept && oor;
        fdata_d     = fdata_q;
        ferr_d      = ferr_q;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        occ_d       = occ_q + Cw'(push) - Cw'(pop);
        if (push) begin
            fdata_d[wptr_q] = push_data;
            ferr_d[wptr_q]  = infl_err_q;
            wptr_d          = ptr_inc(wptr_q);
        end
        if (pop) begin
            rptr_d = ptr_inc(rptr_q);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
`ifdef SRAM_HOST_CLEAR_EN
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
`else
            state_q   <= ST_READY;
`endif
            inflight_q  <= 1'b0;
            infl_read_q <= 1'b0;
            infl_err_q  <= 1'b0;
            occ_q       <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            fdata_q     <= '0;
            ferr_q      <= '0;
        end else begin
            state_q     <= state_d;
`ifdef SRAM_HOST_CLEAR_EN
            clr_cnt_q   <= clr_cnt_d;
`endif
            inflight_q  <= inflight_d;
            infl_read_q <= infl_read_d;
            infl_err_q  <= infl_err_d;
            occ_q       <= occ_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            fdata_q     <= fdata_d;
            ferr_q      <= ferr_d;
        end
    end
endmodule

// File: tb/tb_sram_host_port.sv
// Scoreboard bench for sram_host_port: a driver issues queued requests and
// pushes expected responses on grant; a monitor pops and compares on each response.
module tb_sram_host_port;
    localparam int W  = 32;
    localparam int D  = 64;
    localparam int RD = 3;
`ifdef SRAM_HOST_CLEAR_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_d;
        logic        exp_e;
        bit          lat;
    } req_t;

    typedef struct {
        logic [31:0] d;
        logic        e;
        int          acc;
        bit          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        sram_req, sram_write;
    logic [5:0]  sram_addr;
    logic [31:0] sram_wdata, sram_wmask, sram_rdata;
    logic [31:0] mem [D];

    int          cyc = 0;
    int          pass_cnt = 0;
    int          tot_cnt = 0;
    int          gnt_cnt = 0;
    int          stall_cnt = 0;
    int          rv_cnt = 0;
    int          first_gnt = -1;
    logic [31:0] last_wmask = '0;
    logic        last_sreq = 1'b0;

    req_t req_q[$];
    exp_t exp_q[$];

    sram_host_port_if #(.Width(W)) h ();

    sram_host_port #(.Width(W), .Depth(D), .RespDepth(RD)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .host         (h),
        .sram_req_o   (sram_req),
        .sram_write_o (sram_write),
        .sram_addr_o  (sram_addr),
        .sram_wdata_o (sram_wdata),
        .sram_wmask_o (sram_wmask),
        .sram_rdata_i (sram_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Single-port SRAM with one-cycle registered read; preloaded with a pattern.
    always @(posedge clk) begin
        if (cyc == 0) begin
            for (int i = 0; i < D; i++) mem[i] <= 32'h5A5A_0000 | i;
            sram_rdata <= '0;
        end else if (sram_req) begin
            if (sram_write) mem[sram_addr] <= (mem[sram_addr] & ~sram_wmask) | (sram_wdata & sram_wmask);
            else sram_rdata <= mem[sram_addr];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, required %h (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic add(input logic we, input logic [3:0] be, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] ed, input logic ee, input bit lat);
        req_t r;
        r.we = we; r.be = be; r.addr = a; r.wdata = wd;
        r.exp_d = ed; r.exp_e = ee; r.lat = lat;
        req_q.push_back(r);
    endtask

    task automatic wait_idle(input int max);
        for (int i = 0; i < max; i++) begin
            @(posedge clk);
            if (req_q.size() == 0 && exp_q.size() == 0) return;
        end
        tot_cnt++;
        $display("FAIL wait_idle: still busy after %0d cycles, required idle", max);
    endtask

    // Driver: present queue head, record expected response on grant.
    initial begin
        req_t cur;
        exp_t e;
        h.req_i = 1'b0; h.we_i = 1'b0; h.be_i = '0; h.addr_i = '0; h.wdata_i = '0;
        forever begin
            @(posedge clk); #1;
            if (req_q.size() > 0) begin
                cur = req_q[0];
                h.req_i = 1'b1; h.we_i = cur.we; h.be_i = cur.be;
                h.addr_i = cur.addr; h.wdata_i = cur.wdata;
            end else begin
                h.req_i = 1'b0;
            end
            @(negedge clk);
            if (h.req_i && h.gnt_o) begin
                e.d = cur.exp_d; e.e = cur.exp_e; e.acc = cyc; e.lat = cur.lat;
                exp_q.push_back(e);
                if (req_q.size() > 0) void'(req_q.pop_front());
                gnt_cnt++;
                if (first_gnt < 0) first_gnt = cyc;
                last_sreq = sram_req;
                if (h.we_i) last_wmask = sram_wmask;
                chk("credit_outstanding", 32'(exp_q.size() <= RD + 1), 32'd1);
            end else if (h.req_i) begin
                stall_cnt++;
            end
        end
    end

    // Monitor: compare every accepted response against the scoreboard.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (!rst && h.rvalid_o) rv_cnt++;
            if (!rst && h.rvalid_o && h.rready_i) begin
                if (exp_q.size() == 0) begin
                    tot_cnt++;
                    $display("FAIL unexpected_rsp: got rdata %h err %b, required no response", h.rdata_o, h.err_o);
                end else begin
                    x = exp_q.pop_front();
                    chk("rdata", h.rdata_o, x.d);
                    chk("err", 32'(h.err_o), 32'(x.e));
                    if (x.lat) chk("latency", 32'(cyc - x.acc), 32'd2);
                end
            end
        end
    end

    initial begin
        int r0, g0, s0, rv0;
        rst = 1'b1;
        h.rready_i = 1'b0;
        add(1'b0, 4'h0, 32'h30, '0, CLR ? 32'h0 : 32'h5A5A_000C, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt", 32'(h.gnt_o), 32'd0);
        chk("rst_sram_req", 32'(sram_req), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; h.rready_i = 1'b1; r0 = cyc;
        @(negedge clk);
        chk("post_rst_rvalid", 32'(h.rvalid_o), 32'd0);
        chk("post_rst_rdata", h.rdata_o, 32'd0);
        chk("post_rst_err", 32'(h.err_o), 32'd0);
`ifdef SRAM_HOST_CLEAR_EN
        chk("clr_req_write", 32'(sram_req & sram_write), 32'd1);
        chk("clr_addr", 32'(sram_addr), 32'd0);
        chk("clr_wmask", sram_wmask, 32'hFFFF_FFFF);
        chk("clr_wdata", sram_wdata, 32'd0);
`endif
        wait_idle(D + 40);
        chk("first_gnt_delay", 32'(first_gnt - r0), CLR ? 32'(D) : 32'd0);

        // Write then read
        add(1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b1);
        add(1'b0, 4'h0, 32'h10, '0, 32'hDEAD_BEEF, 1'b0, 1'b1);
        wait_idle(40);

        // Byte masking, low address bits ignored
        add(1'b1, 4'hF, 32'h20, 32'hAAAA_AAAA, 32'h0, 1'b0, 1'b1);
        add(1'b1, 4'h5, 32'h20, 32'h1122_3344, 32'h0, 1'b0, 1'b1);
        wait_idle(40);
        chk("byte_wmask", last_wmask, 32'h00FF_00FF);
        add(1'b0, 4'h0, 32'h20, '0, 32'hAA22_AA44, 1'b0, 1'b1);
        add(1'b0, 4'h0, 32'h23, '0, 32'hAA22_AA44, 1'b0, 1'b1);
        wait_idle(40);

        // Out of range: read past the end, then a write with a high address bit
        add(1'b0, 4'h0, 32'h100, '0, 32'h0, 1'b1, 1'b1);
        wait_idle(40);
        chk("oor_read_sram_req", 32'(last_sreq), 32'd0);
        add(1'b1, 4'hF, 32'h8000_0010, 32'h0000_1234, 32'h0, 1'b1, 1'b1);
        wait_idle(40);
        chk("oor_write_sram_req", 32'(last_sreq), 32'd0);
        add(1'b0, 4'h0, 32'h10, '0, 32'hDEAD_BEEF, 1'b0, 1'b1);
        wait_idle(40);

        // Throughput: 8 back-to-back reads
        g0 = gnt_cnt; s0 = stall_cnt;
        for (int i = 0; i < 8; i++)
            add(1'b0, 4'h0, 32'h40 + 32'(4 * i), '0, CLR ? 32'h0 : 32'h5A5A_0010 + 32'(i), 1'b0, 1'b1);
        wait_idle(60);
        chk("tput_gnts", 32'(gnt_cnt - g0), 32'd8);
        chk("tput_stalls", 32'(stall_cnt - s0), 32'd0);

        // Backpressure
        @(posedge clk); #1;
        h.rready_i = 1'b0; g0 = gnt_cnt;
        add(1'b0, 4'h0, 32'h10, '0, 32'hDEAD_BEEF, 1'b0, 1'b0);
        add(1'b0, 4'h0, 32'h20, '0, 32'hAA22_AA44, 1'b0, 1'b0);
        add(1'b0, 4'h0, 32'h30, '0, CLR ? 32'h0 : 32'h5A5A_000C, 1'b0, 1'b0);
        add(1'b0, 4'h0, 32'h44, '0, CLR ? 32'h0 : 32'h5A5A_0011, 1'b0, 1'b0);
        add(1'b0, 4'h0, 32'h10, '0, 32'hDEAD_BEEF, 1'b0, 1'b0);
        add(1'b0, 4'h0, 32'h20, '0, 32'hAA22_AA44, 1'b0, 1'b0);
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("bp_accepts", 32'(gnt_cnt - g0), 32'(RD));
        chk("bp_gnt_held", 32'(h.gnt_o), 32'd0);
        chk("bp_rvalid", 32'(h.rvalid_o), 32'd1);
        @(posedge clk); #1;
        h.rready_i = 1'b1;
        @(negedge clk);
        chk("bp_gnt_on_pop", 32'(h.gnt_o && h.rvalid_o), 32'd1);
        wait_idle(60);

        // Reset with one read in flight and two FIFO entries
        @(posedge clk); #1;
        h.rready_i = 1'b0; g0 = gnt_cnt;
        for (int i = 0; i < 3; i++) add(1'b0, 4'h0, 32'h10, '0, 32'hDEAD_BEEF, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            if (gnt_cnt - g0 >= 3) break;
        end
        chk("rst_setup_gnts", 32'(gnt_cnt - g0), 32'd3);
        @(posedge clk); #1;
        rst = 1'b1;
        req_q.delete();
        exp_q.delete();
        @(negedge clk);
        chk("rst_setup_rvalid", 32'(h.rvalid_o), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0; h.rready_i = 1'b1; rv0 = rv_cnt;
        repeat (10) @(posedge clk);
        chk("no_rvalid_after_rst", 32'(rv_cnt - rv0), 32'd0);
        add(1'b0, 4'h0, 32'h10, '0, CLR ? 32'h0 : 32'hDEAD_BEEF, 1'b0, 1'b1);
        add(1'b0, 4'h0, 32'h20, '0, CLR ? 32'h0 : 32'hAA22_AA44, 1'b0, 1'b1);
        wait_idle(D + 40);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule
